// File: rtl/popcount_pkg.sv
// Shared defaults for the popcount arbiter: requester count, word widths, id width.
package popcount_pkg;

  localparam int unsigned NREQ_DEF      = 4;
  localparam int unsigned WIDTH_IN_DEF  = 12;
  localparam int unsigned WIDTH_OUT_DEF = 4;
  localparam int unsigned ACC_W_DEF     = 8;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ID_W_DEF = id_w(NREQ_DEF);

endpackage

// File: rtl/adder_12in_1b.sv
// Combinational population count: sums IN_W single-bit inputs into SUM_W bits.
module adder_12in_1b
  import popcount_pkg::*;
#(
  parameter int unsigned IN_W  = WIDTH_IN_DEF,
  parameter int unsigned SUM_W = WIDTH_OUT_DEF + 1
) (
  input  logic [IN_W-1:0]  bits,
  output logic [SUM_W-1:0] sum_c
);

  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < IN_W; i++) begin
      sum_c = sum_c + SUM_W'(bits[i]);
    end
  end

endmodule

// File: rtl/popcount_arb.sv
// Round-robin arbiter sharing one popcount unit, with per-requester saturating accumulators.
module popcount_arb
  import popcount_pkg::*;
#(
  parameter int unsigned NREQ      = NREQ_DEF,
  parameter int unsigned WIDTH_in  = WIDTH_IN_DEF,
  parameter int unsigned WIDTH_out = WIDTH_OUT_DEF,
  parameter int unsigned ACC_W     = ACC_W_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NREQ-1:0]          i_req,
  input  logic [NREQ*WIDTH_in-1:0] i_data,
  input  logic [NREQ-1:0]          i_clr,
  output logic [NREQ-1:0]          o_gnt,
  output logic                     o_valid,
  output logic [id_w(NREQ)-1:0]    o_id,
  output logic [WIDTH_out:0]       o_sum,
  output logic [NREQ*ACC_W-1:0]    o_acc
);

  localparam int unsigned ID_W  = id_w(NREQ);
  localparam int unsigned SUM_W = WIDTH_out + 1;

  logic [ID_W-1:0]        last_winner;
  logic [ID_W-1:0]        win_id;
  logic [ID_W-1:0]        cand;
  logic                   win_found;
  logic [NREQ-1:0]        eligible;
  logic [WIDTH_in-1:0]    operand;
  logic [ID_W-1:0]        stage_id;
  logic                   stage_valid;
  logic [SUM_W-1:0]       sum_c;
  logic [ACC_W-1:0]       acc_cur;
  logic [NREQ*ACC_W-1:0]  acc_nxt;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [SUM_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W+1)'(b);
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  // The requester currently holding the grant sits out this edge.
  assign eligible = i_req & ~o_gnt;

  // Round-robin search starting just after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_id    = last_winner;
    cand      = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = ID_W'((32'(last_winner) + i) % NREQ);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Grant and operand capture stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_gnt       <= '0;
      operand     <= '0;
      stage_id    <= '0;
      stage_valid <= 1'b0;
      last_winner <= ID_W'(NREQ - 1);
    end else begin
      stage_valid <= win_found;
      if (win_found) begin
        o_gnt       <= NREQ'(1) << win_id;
        operand     <= i_data[32'(win_id)*WIDTH_in +: WIDTH_in];
        stage_id    <= win_id;
        last_winner <= win_id;
      end else begin
        o_gnt <= '0;
      end
    end
  end

  adder_12in_1b #(
    .IN_W  (WIDTH_in),
    .SUM_W (SUM_W)
  ) u_adder (
    .bits  (operand),
    .sum_c (sum_c)
  );

  // Clear applies first, so a same-edge clear and update leaves just the new sum.
  always_comb begin
    acc_nxt = o_acc;
    acc_cur = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      acc_cur = i_clr[k] ? '0 : o_acc[k*ACC_W +: ACC_W];
      if (stage_valid && stage_id == ID_W'(k)) begin
        acc_nxt[k*ACC_W +: ACC_W] = sat_add(acc_cur, sum_c);
      end else begin
        acc_nxt[k*ACC_W +: ACC_W] = acc_cur;
      end
    end
  end

  // Result stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_id    <= '0;
      o_sum   <= '0;
      o_acc   <= '0;
    end else begin
      o_valid <= stage_valid;
      o_id    <= stage_id;
      o_sum   <= sum_c;
      o_acc   <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_popcount_arb.sv
// Directed bench for popcount_arb: reset, round-robin, spacing, saturation, clear, mid-run reset.
module tb_popcount_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [47:0] data;
  logic [3:0]  clr;
  logic [3:0]  gnt;
  logic        valid;
  logic [1:0]  id;
  logic [4:0]  sum;
  logic [31:0] acc;

  int checks = 0;
  int passed = 0;

  popcount_arb dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (req),
    .i_data  (data),
    .i_clr   (clr),
    .o_gnt   (gnt),
    .o_valid (valid),
    .o_id    (id),
    .o_sum   (sum),
    .o_acc   (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    req = '0;
    clr = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One grant then its result; no checks here.
  task automatic send(input int k, input logic [11:0] word);
    data[k*12 +: 12] = word;
    req[k] = 1'b1;
    tick();
    req = '0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0; clr = '0; data = '0;
    tick(); tick();
    checks++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got=%b exp=0000", gnt); else passed++;
    checks++; if (valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid); else passed++;
    checks++; if (id !== 2'd0) $display("FAIL reset_id got=%0d exp=0", id); else passed++;
    checks++; if (sum !== 5'd0) $display("FAIL reset_sum got=%0d exp=0", sum); else passed++;
    checks++; if (acc !== 32'd0) $display("FAIL reset_acc got=%h exp=0", acc); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    data[11:0] = 12'hFFF;
    req = 4'b0001;
    tick();
    checks++; if (gnt !== 4'b0001) $display("FAIL single_gnt got=%b exp=0001", gnt); else passed++;
    checks++; if (valid !== 1'b0) $display("FAIL single_early_valid got=%b exp=0", valid); else passed++;
    req = '0;
    tick();
    checks++; if (valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", valid); else passed++;
    checks++; if (id !== 2'd0) $display("FAIL single_id got=%0d exp=0", id); else passed++;
    checks++; if (sum !== 5'b01100) $display("FAIL single_sum got=%0d exp=12", sum); else passed++;
    checks++; if (acc[7:0] !== 8'd12) $display("FAIL single_acc0 got=%0d exp=12", acc[7:0]); else passed++;
    checks++; if (gnt !== 4'b0000) $display("FAIL single_gnt_drop got=%b exp=0000", gnt); else passed++;
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_sum [4];
    exp_sum[0] = 5'd1; exp_sum[1] = 5'd2; exp_sum[2] = 5'd4; exp_sum[3] = 5'd12;
    reset_dut();
    data = {12'hFFF, 12'h0F0, 12'h003, 12'h001};
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (gnt !== 4'(1 << (c % 4))) $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, gnt, 4'(1 << (c % 4)));
      else passed++;
      if (c == 0) begin
        checks++; if (valid !== 1'b0) $display("FAIL rr_first_valid got=%b exp=0", valid); else passed++;
      end else begin
        checks++; if (valid !== 1'b1) $display("FAIL rr_valid c=%0d got=%b exp=1", c, valid); else passed++;
        checks++;
        if (id !== 2'((c - 1) % 4)) $display("FAIL rr_id c=%0d got=%0d exp=%0d", c, id, (c - 1) % 4);
        else passed++;
        checks++;
        if (sum !== exp_sum[(c - 1) % 4]) $display("FAIL rr_sum c=%0d got=%0d exp=%0d", c, sum, exp_sum[(c - 1) % 4]);
        else passed++;
      end
    end
    req = '0;
    tick();
    checks++; if (gnt !== 4'b0000) $display("FAIL rr_idle_gnt got=%b exp=0000", gnt); else passed++;
    checks++; if (valid !== 1'b1 || id !== 2'd3 || sum !== 5'd12)
      $display("FAIL rr_tail got=v%b id%0d s%0d exp=v1 id3 s12", valid, id, sum); else passed++;
    checks++; if (acc !== {8'd24, 8'd8, 8'd4, 8'd2})
      $display("FAIL rr_acc got=%h exp=%h", acc, {8'd24, 8'd8, 8'd4, 8'd2}); else passed++;
    tick();
    checks++; if (valid !== 1'b0) $display("FAIL rr_idle_valid got=%b exp=0", valid); else passed++;
  endtask

  task automatic test_single_repeat();
    reset_dut();
    data[2*12 +: 12] = 12'h00F;
    req = 4'b0100;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (gnt !== ((c % 2 == 0) ? 4'b0100 : 4'b0000))
        $display("FAIL spacing_gnt c=%0d got=%b exp=%b", c, gnt, (c % 2 == 0) ? 4'b0100 : 4'b0000);
      else passed++;
      checks++;
      if (valid !== 1'((c % 2) == 1)) $display("FAIL spacing_valid c=%0d got=%b exp=%b", c, valid, (c % 2) == 1);
      else passed++;
      if (c % 2 == 1) begin
        checks++;
        if (sum !== 5'd4 || id !== 2'd2) $display("FAIL spacing_result c=%0d got=s%0d id%0d exp=s4 id2", c, sum, id);
        else passed++;
      end
    end
    req = '0;
  endtask

  task automatic test_saturate();
    int exp_acc = 0;
    reset_dut();
    data[1*12 +: 12] = 12'hFFF;
    req = 4'b0010;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (c % 2 == 1) begin
        exp_acc = (exp_acc + 12 > 255) ? 255 : exp_acc + 12;
        checks++;
        if (valid !== 1'b1 || acc[15:8] !== 8'(exp_acc))
          $display("FAIL sat_acc1 c=%0d got=v%b acc%0d exp=v1 acc%0d", c, valid, acc[15:8], exp_acc);
        else passed++;
      end
    end
    req = '0;
    checks++; if (acc[15:8] !== 8'd255) $display("FAIL sat_final got=%0d exp=255", acc[15:8]); else passed++;
  endtask

  task automatic test_clear();
    reset_dut();
    send(3, 12'hFFF); send(3, 12'hFFF); send(3, 12'hFFF); send(3, 12'h00F);
    checks++; if (acc[31:24] !== 8'd40) $display("FAIL clr_pre got=%0d exp=40", acc[31:24]); else passed++;
    data[3*12 +: 12] = 12'h01F;
    req = 4'b1000;
    tick();
    req = '0;
    clr = 4'b1000;
    tick();
    clr = '0;
    checks++; if (valid !== 1'b1 || acc[31:24] !== 8'd5)
      $display("FAIL clr_with_update got=v%b acc%0d exp=v1 acc5", valid, acc[31:24]); else passed++;
    clr = 4'b1000;
    tick();
    clr = '0;
    checks++; if (acc[31:24] !== 8'd0) $display("FAIL clr_no_update got=%0d exp=0", acc[31:24]); else passed++;
  endtask

  task automatic test_reset_mid();
    reset_dut();
    send(2, 12'hFFF);
    data[1*12 +: 12] = 12'h0FF;
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) $display("FAIL mid_pre_gnt got=%b exp=0010", gnt); else passed++;
    req = '0;
    rst = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0000 || valid !== 1'b0 || id !== 2'd0 || sum !== 5'd0 || acc !== 32'd0)
      $display("FAIL mid_rst_outputs got=g%b v%b id%0d s%0d acc%h exp=all zero", gnt, valid, id, sum, acc);
    else passed++;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (valid !== 1'b0) $display("FAIL mid_no_valid got=%b exp=0", valid); else passed++;
    req = 4'b1111;
    tick();
    checks++; if (gnt !== 4'b0001) $display("FAIL mid_next_gnt got=%b exp=0001", gnt); else passed++;
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_single_repeat();
    test_saturate();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/popcount_arb.md
POPCOUNT_ARB -- requirements
Module: popcount_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the popcount unit.
REQ-002 Parameter WIDTH_in, default 12, bits per request word.
REQ-003 Parameter WIDTH_out, default 4; sum output is WIDTH_out+1 bits wide.
REQ-004 Parameter ACC_W, default 8, per-requester accumulator width.
REQ-005 The block SHALL have one clock, i_clk; reset i_rst is asynchronous and active-high.
REQ-006 i_clk  input  1  rising-edge clock.
REQ-007 i_rst  input  1  asynchronous active-high reset.
REQ-008 i_req  input  NREQ  per-requester request, level, held until granted.
REQ-009 i_data  input  NREQ*WIDTH_in  request words, slice k = i_data[k*WIDTH_in +: WIDTH_in].
REQ-010 i_clr  input  NREQ  per-requester accumulator clear, single-cycle pulse.
REQ-011 o_gnt  output  NREQ  one-hot grant pulse, registered.
REQ-012 o_valid  output  1  result-valid pulse, registered.
REQ-013 o_id  output  clog2(NREQ)  index of requester owning the current result.
REQ-014 o_sum  output  WIDTH_out+1  number of set bits in the granted word.
REQ-015 o_acc  output  NREQ*ACC_W  per-requester saturating running totals.

Function
REQ-016 At each rising edge, if any eligible i_req bit is set, the block SHALL select exactly one winner round-robin, searching from (last_winner+1) mod NREQ upward.
REQ-017 The requester holding o_gnt high in a cycle SHALL be ineligible at the edge ending that cycle (prevents a double grant); the same requester is granted at most every other cycle.
REQ-018 At the winning edge E0: o_gnt <= onehot(w); operand register <= i_data slice w; stage id <= w; stage valid <= 1; last_winner <= w.
REQ-019 With no eligible request at an edge, o_gnt SHALL be all zero and stage valid 0 for the next cycle; last_winner is unchanged.
REQ-020 At edge E1 (the edge after E0): o_sum <= popcount(operand register); o_id <= stage id; o_valid <= stage valid.
REQ-021 Latency: o_gnt high one cycle after request sampling; o_valid high exactly one cycle after o_gnt; sustained throughput is one result per cycle with two or more requesters active.
REQ-022 o_sum SHALL range 0..WIDTH_in; all-ones word yields 12 (5'b01100).
REQ-023 At E1 with stage valid set, acc[o_id] SHALL be updated to min(acc + sum, 2^ACC_W-1); no wrap-around.
REQ-024 i_clr[k] at an edge with no update to k: acc[k] <= 0.
REQ-025 i_clr[k] and an update to k at the same edge: acc[k] <= sum (clear, then add).
REQ-026 o_acc SHALL reflect the updated value in the same cycle o_valid is high.
REQ-027 Changes to i_data while i_req is low SHALL have no effect; data is captured only at the winning edge.

Reset
REQ-028 While i_rst is high: o_gnt=0, o_valid=0, o_id=0, o_sum=0, all accumulators 0, stage valid 0.
REQ-029 Reset SHALL set last_winner = NREQ-1, so requester 0 has first priority after reset.
REQ-030 Reset mid-operation SHALL discard in-flight grants and results; no o_valid pulse for pre-reset requests.

Structure
REQ-031 NREQ, WIDTH_in, WIDTH_out and ACC_W defaults plus the id-width constant SHALL reside in shared package popcount_pkg.
REQ-032 The popcount SHALL be a single instance of adder_12in_1b fed from the operand register; the arbiter, pipeline registers and accumulators stay in popcount_arb.

Verification
REQ-033 Reset release, i_req=4'b0001, word 12'hFFF -> o_gnt=4'b0001 next cycle, then o_valid=1, o_id=0, o_sum=12, acc0=12.
REQ-034 i_req=4'b1111 held continuously -> grants cycle 0,1,2,3,0,... one per cycle; o_sum matches each word's popcount.
REQ-035 Only i_req[2] held high with word 12'h00F -> o_gnt[2] every other cycle, never two consecutive cycles.
REQ-036 Requester 1 repeatedly sends 12'hFFF (sum 12) -> acc1 climbs 12, 24, ... and saturates at 255, never wraps.
REQ-037 i_clr[3] on the edge where acc3 is updated with sum 5 (acc3 previously 40) -> acc3=5; i_clr[3] with no update -> acc3=0.
REQ-038 Assert i_rst the cycle after a grant -> no o_valid pulse follows; all outputs 0; the next grant goes to requester 0.
